// File: rtl/vedic_pkg.sv
// Shared definitions for the vedic serial-transmit slice: the FSM state
// type and the default product width.
// Build option: PISO_PARITY_EN adds the PARITY state.
package vedic_pkg;

    localparam int unsigned VEDIC_PROD_W = 8;

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } piso_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DONE   = 2'd3
    } piso_state_t;
`endif

endpackage

// File: rtl/vedic_piso_tx_if.sv
// Load handshake and serial output bundle of vedic_piso_tx.
// master: the word producer / serial observer; slave: the transmitter.
interface vedic_piso_tx_if #(
    parameter int unsigned W = vedic_pkg::VEDIC_PROD_W
);
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         load_ready;
    logic         sdo;
    logic         sframe;
    logic         sdone;

    modport master (
        output load_valid, load_data,
        input  load_ready, sdo, sframe, sdone
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, sdo, sframe, sdone
    );
endinterface

// File: rtl/vedic_shreg.sv
// W-bit load / shift-left register with asynchronous clear.
// Load has priority over shift; zeros enter at the LSB.
module vedic_shreg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture a fresh word or move every bit one place toward the MSB.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            q <= '0;
        else if (load)
            q <= d;
        else if (shift)
            q <= {q[W-2:0], 1'b0};
    end

endmodule

// File: rtl/vedic_piso_tx.sv
// Parallel-in serial-out transmitter for a product word, MSB first.
// A word is framed for W cycles (W+1 with the optional even-parity bit),
// followed by a one-cycle sdone pulse.
// Build option: define PISO_PARITY_EN to append the parity bit.
module vedic_piso_tx
    import vedic_pkg::*;
#(
    parameter int unsigned W = VEDIC_PROD_W
) (
    input  logic          CP,
    input  logic          RST,
    vedic_piso_tx_if.slave bus
);

    localparam int unsigned   CW   = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    piso_state_t   state;
    piso_state_t   state_nxt;
    logic [CW-1:0] cnt;
    logic [W-1:0]  sh_q;
    logic          accept;
    logic          in_shift;

    assign accept   = bus.load_valid && (state == ST_IDLE);
    assign in_shift = (state == ST_SHIFT);

    vedic_shreg #(.W(W)) u_shreg (
        .clk   (CP),
        .clr   (RST),
        .load  (accept),
        .shift (in_shift),
        .d     (bus.load_data),
        .q     (sh_q)
    );

`ifdef PISO_PARITY_EN
    logic par_q;

    // Even parity is taken from the word as captured, since the shift
    // register no longer holds it by the time the parity bit goes out.
    always_ff @(posedge CP or posedge RST) begin
        if (RST)
            par_q <= 1'b0;
        else if (accept)
            par_q <= ^bus.load_data;
    end
`endif

    // State register.
    always_ff @(posedge CP or posedge RST) begin
        if (RST)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Bit counter: cleared on accept, counts SHIFT cycles.
    always_ff @(posedge CP or posedge RST) begin
        if (RST)
            cnt <= '0;
        else if (accept)
            cnt <= '0;
        else if (in_shift)
            cnt <= cnt + CW'(1);
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.load_valid) state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (cnt == LAST) begin
`ifdef PISO_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_DONE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: state_nxt = ST_DONE;
`endif
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state so reset forces them without a clock edge.
    always_comb begin
        bus.load_ready = (state == ST_IDLE);
        bus.sdone      = (state == ST_DONE);
        bus.sframe     = in_shift;
        bus.sdo        = in_shift ? sh_q[W-1] : 1'b0;
`ifdef PISO_PARITY_EN
        if (state == ST_PARITY) begin
            bus.sframe = 1'b1;
            bus.sdo    = par_q;
        end
`endif
    end

endmodule

// File: tb/tb_vedic_piso_tx.sv
// Self-checking bench for vedic_piso_tx (W=8). Expected serial bits are
// queued when a word is accepted and popped on each framed cycle.
// Works with PISO_PARITY_EN defined or undefined.
module tb_vedic_piso_tx;
    import vedic_pkg::*;

    localparam int unsigned W = 8;
`ifdef PISO_PARITY_EN
    localparam int unsigned SPACING = W + 3;
`else
    localparam int unsigned SPACING = W + 2;
`endif

    logic CP;
    logic RST;

    vedic_piso_tx_if #(.W(W)) bus ();

    vedic_piso_tx #(.W(W)) dut (
        .CP  (CP),
        .RST (RST),
        .bus (bus.slave)
    );

    int          n_checks   = 0;
    int          n_errors   = 0;
    int          n_acc      = 0;
    int          n_done     = 0;
    int          n_done_exp = 0;
    int unsigned cyc        = 0;
    bit          first_pending = 0;
    bit          done_prev     = 0;
    bit          exp_q[$];
    int unsigned acc_q[$];

    initial CP = 1'b0;
    always #5 CP = ~CP;

    always @(posedge CP) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge CP) begin
        if (!RST) begin
            if (first_pending) begin
                check_eq("first_bit_latency", bus.sframe, 1);
                first_pending = 0;
            end
            if (done_prev) begin
                check_eq("ready_after_done", bus.load_ready, 1);
                done_prev = 0;
            end
            if (bus.sframe) begin
                if (exp_q.size() == 0)
                    check_eq("unexpected_sframe", bus.sframe, 0);
                else
                    check_eq("sdo_bit", bus.sdo, exp_q.pop_front());
            end
            if (bus.sdone) begin
                n_done++;
                check_eq("done_queue_empty", exp_q.size(), 0);
                check_eq("done_sframe", bus.sframe, 0);
                check_eq("done_ready", bus.load_ready, 0);
                check_eq("done_sdo", bus.sdo, 0);
                done_prev = 1;
            end
            if (bus.load_valid && bus.load_ready) begin
                for (int i = W - 1; i >= 0; i--)
                    exp_q.push_back(bus.load_data[i]);
`ifdef PISO_PARITY_EN
                exp_q.push_back(^bus.load_data);
`endif
                n_acc++;
                n_done_exp++;
                acc_q.push_back(cyc);
                first_pending = 1;
            end
        end
    end

    // Offer a word and return just after the accepting edge.
    task automatic send(input logic [W-1:0] w);
        int start;
        int i;
        @(posedge CP); #1;
        bus.load_valid = 1'b1;
        bus.load_data  = w;
        start = n_acc;
        i = 0;
        while (n_acc == start && i < 50) begin
            @(posedge CP);
            i++;
        end
        check_eq("accept_seen", n_acc, start + 1);
        #1;
        bus.load_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while ((exp_q.size() != 0 || !bus.load_ready) && i < 100) begin
            @(posedge CP); #1;
            i++;
        end
        check_eq("idle_reached", (exp_q.size() == 0 && bus.load_ready), 1);
        @(posedge CP); #1;
    endtask

    initial begin
        int i;
        int start;
        RST = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;

        // Reset forces outputs before any clock edge.
        #1 RST = 1'b1;
        #1;
        check_eq("rst_ready", bus.load_ready, 1);
        check_eq("rst_sframe", bus.sframe, 0);
        check_eq("rst_sdo", bus.sdo, 0);
        check_eq("rst_sdone", bus.sdone, 0);
        repeat (2) @(posedge CP);
        #1 RST = 1'b0;

        // Basic and parity sends.
        send(8'hA5);
        wait_idle();
        send(8'h01);
        wait_idle();

        // Busy: a second offer during SHIFT cycles 3..5 is ignored.
        send(8'h3C);
        repeat (3) @(posedge CP);
        #1;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hFF;
        check_eq("busy_ready", bus.load_ready, 0);
        repeat (2) begin
            @(posedge CP); #1;
            check_eq("busy_ready", bus.load_ready, 0);
        end
        @(posedge CP); #1;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        wait_idle();

        // Reset between edges in SHIFT cycle 4 aborts the word.
        send(8'hA5);
        repeat (4) @(posedge CP);
        #2 RST = 1'b1;
        #1;
        check_eq("abort_sframe", bus.sframe, 0);
        check_eq("abort_ready", bus.load_ready, 1);
        check_eq("abort_sdo", bus.sdo, 0);
        check_eq("abort_sdone", bus.sdone, 0);
        exp_q.delete();
        n_done_exp--;
        repeat (2) @(posedge CP);
        #1 RST = 1'b0;
        send(8'h81);
        wait_idle();

        // Back-to-back with load_valid held high.
        @(posedge CP); #1;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h55;
        start = n_acc;
        i = 0;
        while (n_acc == start && i < 50) begin @(posedge CP); i++; end
        check_eq("b2b_first_accept", n_acc, start + 1);
        #1 bus.load_data = 8'hAA;
        i = 0;
        while (n_acc == start + 1 && i < 50) begin @(posedge CP); i++; end
        check_eq("b2b_second_accept", n_acc, start + 2);
        #1 bus.load_valid = 1'b0;
        if (acc_q.size() >= 2)
            check_eq("b2b_spacing", acc_q[$] - acc_q[$-1], SPACING);
        wait_idle();

        check_eq("done_count", n_done, n_done_exp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
